// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that owns the single register-file write port for four requesters.
// Optional burst locking is enabled by defining ARB_LOCK_EN.
module regfile_write_arbiter #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned MAX_LOCK  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [4*ADDR_BITS-1:0] req_addr,
  input  logic [4*DATA_BITS-1:0] req_data,
  input  logic [3:0]             req_lock,
  output logic [3:0]             gnt,
  output logic                   wr_en,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [DATA_BITS-1:0]   wr_data,
  output logic [1:0]             src_sel,
  output logic                   locked
);

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned CNT_BITS = 8;

  logic [1:0] ptr;
  logic [3:0] mask;
  logic [3:0] elig_c;
  logic       found_c;
  logic [1:0] win_c;

  logic       sel_c;
  logic [1:0] win_sel_c;
  logic       mask_set_c;
  logic [1:0] ptr_next;
  logic       locked_next;

  // First eligible requester at or after the pointer, wrapping modulo 4
  always_comb begin
    elig_c  = req & ~mask;
    found_c = 1'b0;
    win_c   = ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found_c && elig_c[ptr + 2'(k)]) begin
        found_c = 1'b1;
        win_c   = ptr + 2'(k);
      end
    end
  end

`ifdef ARB_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_next;
  logic [1:0]          owner, owner_next;
  logic [CNT_BITS-1:0] count, count_next;
  logic                at_max_c;

  assign at_max_c = (count + CNT_BITS'(1)) == CNT_BITS'(MAX_LOCK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    count_next = count;
    case (state)
      IDLE: begin
        if (found_c && req_lock[win_c]) begin
          state_next = LOCKED;
          owner_next = win_c;
          count_next = CNT_BITS'(1);
        end
      end
      LOCKED: begin
        if (!req[owner] || !req_lock[owner] || at_max_c) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + CNT_BITS'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // While locked the owner bypasses the mask; the mask is only set after a max-length burst
  always_comb begin
    sel_c       = found_c;
    win_sel_c   = win_c;
    mask_set_c  = found_c;
    ptr_next    = found_c ? win_c + 2'd1 : ptr;
    locked_next = 1'b0;
    case (state)
      IDLE: begin
        if (found_c && req_lock[win_c]) begin
          mask_set_c  = 1'b0;
          locked_next = 1'b1;
        end
      end
      LOCKED: begin
        sel_c       = req[owner];
        win_sel_c   = owner;
        ptr_next    = owner + 2'd1;
        locked_next = req[owner];
        mask_set_c  = req[owner] && at_max_c;
      end
      default: sel_c = 1'b0;
    endcase
  end
`else
  logic lock_unused;
  assign lock_unused = ^{req_lock, CNT_BITS'(MAX_LOCK)};

  always_comb begin
    sel_c       = found_c;
    win_sel_c   = win_c;
    mask_set_c  = found_c;
    ptr_next    = found_c ? win_c + 2'd1 : ptr;
    locked_next = 1'b0;
  end
`endif

  // Registered write port; address, data and select hold when no write is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      src_sel <= '0;
      locked  <= 1'b0;
      ptr     <= '0;
      mask    <= '0;
    end else begin
      gnt    <= sel_c ? (4'b0001 << win_sel_c) : 4'b0000;
      wr_en  <= sel_c;
      locked <= locked_next;
      ptr    <= ptr_next;
      mask   <= mask_set_c ? (4'b0001 << win_sel_c) : 4'b0000;
      if (sel_c) begin
        wr_addr <= req_addr[32'(win_sel_c) * ADDR_BITS +: ADDR_BITS];
        wr_data <= req_data[32'(win_sel_c) * DATA_BITS +: DATA_BITS];
        src_sel <= win_sel_c;
      end
    end
  end

endmodule
